// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780-style single write bus-phase sequencer
//
// Sequences one LCD write through setup, enable pulse, hold and execution wait.
// Phase lengths are counted in pulses returned by an external tick timer.
//
// Ports:
//   clock         system clock
//   rst           asynchronous active-high reset
//   start         write request (sampled in IDLE only)
//   rs_in         0 = command, 1 = data
//   data_in       byte to write
//   timer_tick    one-cycle pulse from the tick timer
//   timer_enable  count request to the tick timer
//   lcd_rs        LCD register select
//   lcd_rw        LCD read/write (always write)
//   lcd_e         LCD enable strobe
//   lcd_db        LCD data bus
//   busy          write in progress
//   done          one-cycle completion pulse
`timescale 1ns/1ps
module lcd_write_sequencer #(
   parameter int unsigned SETUP_TICKS     = 1,
   parameter int unsigned PULSE_TICKS     = 1,
   parameter int unsigned HOLD_TICKS      = 1,
   parameter int unsigned EXEC_TICKS      = 1,
   parameter int unsigned LONG_EXEC_TICKS = 16
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic       rs_in,
   input  logic [7:0] data_in,
   input  logic       timer_tick,
   output logic       timer_enable,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_db,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

   // Index of the final tick in a phase; a length of 0 behaves as 1.
   function automatic logic [7:0] last_of(input int unsigned n);
      int unsigned m;
      m = (n == 0) ? 32'd1 : n;
      return 8'(m - 32'd1);
   endfunction

   localparam logic [7:0] SETUP_LAST = last_of(SETUP_TICKS);
   localparam logic [7:0] PULSE_LAST = last_of(PULSE_TICKS);
   localparam logic [7:0] HOLD_LAST  = last_of(HOLD_TICKS);
   localparam logic [7:0] EXEC_LAST  = last_of(EXEC_TICKS);
   localparam logic [7:0] LONG_LAST  = last_of(LONG_EXEC_TICKS);

   state_t     state;
   logic [7:0] count;
   logic       long_exec;
   logic [7:0] limit;
   logic       phase_end;

   assign lcd_rw = 1'b0;

   always_comb begin
      limit = 8'd0;
      case (state)
         SETUP:   limit = SETUP_LAST;
         PULSE:   limit = PULSE_LAST;
         HOLD:    limit = HOLD_LAST;
         EXEC:    limit = long_exec ? LONG_LAST : EXEC_LAST;
         default: limit = 8'd0;
      endcase
   end

   // Only meaningful in the wait states; IDLE/DONE never consult it.
   assign phase_end = timer_tick && (count == limit);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= 8'd0;
         long_exec    <= 1'b0;
         timer_enable <= 1'b0;
         lcd_rs       <= 1'b0;
         lcd_e        <= 1'b0;
         lcd_db       <= 8'h00;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // The bus outputs themselves hold the latched request.
                  lcd_rs       <= rs_in;
                  lcd_db       <= data_in;
                  long_exec    <= !rs_in && (data_in == 8'h01 || data_in[7:1] == 7'h01);
                  count        <= 8'd0;
                  timer_enable <= 1'b1;
                  busy         <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP, PULSE, HOLD, EXEC: begin
               if (phase_end) begin
                  count <= 8'd0;
                  case (state)
                     SETUP: begin
                        lcd_e <= 1'b1;
                        state <= PULSE;
                     end
                     PULSE: begin
                        lcd_e <= 1'b0;
                        state <= HOLD;
                     end
                     HOLD: begin
                        state <= EXEC;
                     end
                     default: begin
                        // Timer is released so its period restarts with the next write.
                        timer_enable <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                     end
                  endcase
               end else if (timer_tick) begin
                  count <= count + 8'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - self-checking bench for lcd_write_sequencer
`timescale 1ns/1ps
module tb_lcd_write_sequencer;

   typedef struct {
      logic       sel;
      logic       rs;
      logic [7:0] d;
      int         iv0;
      int         iv1;
      int         iv2;
      int         e_rise;
      int         e_fall;
      int         done_tick;
   } vec_t;

   typedef struct {
      logic       rs;
      logic [7:0] db;
      int         done_tick;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       sel = 1'b0;
   logic       rs_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       timer_tick = 1'b0;

   logic       te1, rs1, rw1, e1, busy1, done1;
   logic [7:0] db1;
   logic       te2, rs2, rw2, e2, busy2, done2;
   logic [7:0] db2;
   logic       start1, start2;

   logic       m_te, m_rs, m_rw, m_e, m_busy, m_done;
   logic [7:0] m_db;

   int n_checks = 0;
   int n_fail = 0;
   int cur_vec = 0;
   exp_t sb[$];
   vec_t vecs[10];

   assign start1 = start & ~sel;
   assign start2 = start & sel;

   assign m_te   = sel ? te2   : te1;
   assign m_rs   = sel ? rs2   : rs1;
   assign m_rw   = sel ? rw2   : rw1;
   assign m_e    = sel ? e2    : e1;
   assign m_busy = sel ? busy2 : busy1;
   assign m_done = sel ? done2 : done1;
   assign m_db   = sel ? db2   : db1;

   lcd_write_sequencer dut1 (
      .clock(clock), .rst(rst), .start(start1), .rs_in(rs_in), .data_in(data_in),
      .timer_tick(timer_tick), .timer_enable(te1), .lcd_rs(rs1), .lcd_rw(rw1),
      .lcd_e(e1), .lcd_db(db1), .busy(busy1), .done(done1)
   );

   lcd_write_sequencer #(.SETUP_TICKS(2), .PULSE_TICKS(3)) dut2 (
      .clock(clock), .rst(rst), .start(start2), .rs_in(rs_in), .data_in(data_in),
      .timer_tick(timer_tick), .timer_enable(te2), .lcd_rs(rs2), .lcd_rw(rw2),
      .lcd_e(e2), .lcd_db(db2), .busy(busy2), .done(done2)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL v%0d %s: got %0h expected %0h", cur_vec, name, act, exp);
      end
   endtask

   task automatic run_one(input vec_t v);
      exp_t e;
      int   iv[3];
      int   c, gap, k, tick_n, last_tick, windows, rise_t, fall_t, rise_gap, fall_gap;
      bit   got, db_ok, te_ok, rw_ok;
      logic prev_e;
      iv[0] = v.iv0; iv[1] = v.iv1; iv[2] = v.iv2;
      gap = 0; k = 0; tick_n = 0; last_tick = -100; windows = 0;
      rise_t = -1; fall_t = -1; rise_gap = -1; fall_gap = -1;
      got = 0; db_ok = 1; te_ok = 1; rw_ok = 1; prev_e = 1'b0;
      sb.delete();
      sb.push_back('{v.rs, v.d, v.done_tick});
      sel = v.sel;
      rs_in = v.rs; data_in = v.d; start = 1'b1;
      timer_tick = 1'b1;                 // tick in IDLE must be ignored
      @(posedge clock); #1;
      start = 1'b0; data_in = ~v.d; rs_in = ~v.rs; timer_tick = 1'b0;
      c = 1;
      check("start_busy", m_busy, 1);
      check("start_te", m_te, 1);
      check("start_db", m_db, v.d);
      while (!got && c < 3000) begin
         if (m_rw !== 1'b0) rw_ok = 0;
         if (!m_done && (m_db !== v.d || m_rs !== v.rs)) db_ok = 0;
         if (!m_done && m_te !== 1'b1) te_ok = 0;
         if (m_e && !prev_e) begin windows++; rise_t = tick_n; rise_gap = c - last_tick; end
         if (!m_e && prev_e) begin fall_t = tick_n; fall_gap = c - last_tick; end
         prev_e = m_e;
         if (m_done) begin
            got = 1;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("sb_rs", m_rs, e.rs);
               check("sb_db", m_db, e.db);
               check("sb_done_tick", tick_n, e.done_tick);
            end
            check("done_gap", c - last_tick, 1);
            check("done_te", m_te, 0);
            check("done_e", m_e, 0);
            timer_tick = 1'b1;           // tick in DONE must be ignored
         end else begin
            gap++;
            timer_tick = (gap >= iv[k % 3]);
            if (timer_tick) begin
               gap = 0; k++; tick_n++; last_tick = c;
            end
         end
         @(posedge clock); #1;
         c++;
      end
      check("timeout", got, 1);
      timer_tick = 1'b0;
      check("idle_busy", m_busy, 0);
      check("idle_done", m_done, 0);
      check("idle_te", m_te, 0);
      check("idle_db_kept", m_db, v.d);
      check("e_windows", windows, 1);
      check("e_rise_tick", rise_t, v.e_rise);
      check("e_fall_tick", fall_t, v.e_fall);
      check("e_rise_gap", rise_gap, 1);
      check("e_fall_gap", fall_gap, 1);
      check("bus_stable", db_ok, 1);
      check("te_busy", te_ok, 1);
      check("rw_zero", rw_ok, 1);
   endtask

   task automatic run_held();
      logic [7:0] d[3];
      exp_t e;
      int   c, gap, ndone;
      bit   prev_done, db_ok, te_ok;
      d[0] = 8'h11; d[1] = 8'h02; d[2] = 8'hC3;
      cur_vec = 50; sel = 1'b0; sb.delete();
      gap = 0; ndone = 0; prev_done = 0; db_ok = 1; te_ok = 1;
      rs_in = 1'b1; data_in = d[0]; start = 1'b1;
      sb.push_back('{1'b1, d[0], 0});
      c = 0;
      while (ndone < 3 && c < 3000) begin
         @(posedge clock); #1;
         c++;
         if (prev_done && (m_te !== 1'b0 || m_busy !== 1'b0)) te_ok = 0;
         prev_done = 0;
         if (m_done) begin
            if (m_te !== 1'b0) te_ok = 0;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("held_db", m_db, e.db);
            end
            ndone++;
            prev_done = 1;
            if (ndone < 3) begin
               data_in = d[ndone];
               sb.push_back('{1'b1, d[ndone], 0});
            end else begin
               start = 1'b0;
            end
         end else if (m_busy) begin
            if (sb.size() > 0 && m_db !== sb[0].db) db_ok = 0;
            data_in = 8'($urandom);      // mid-write changes must not reach the bus
         end
         gap++;
         timer_tick = (gap >= 3);
         if (timer_tick) gap = 0;
      end
      @(posedge clock); #1;
      timer_tick = 1'b0;
      check("held_idle_te", m_te, 0);
      check("held_dones", ndone, 3);
      check("held_db_stable", db_ok, 1);
      check("held_te_drop", te_ok, 1);
      repeat (3) @(posedge clock);
      #1;
      check("held_no_fourth", m_busy, 0);
   endtask

   task automatic run_reset();
      int  c, gap;
      bit  seen_e, no_done;
      cur_vec = 60; sel = 1'b0;
      gap = 0; seen_e = 0; no_done = 1;
      rs_in = 1'b1; data_in = 8'h5A; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      c = 0;
      while (!seen_e && c < 200) begin
         if (m_e) seen_e = 1;
         else begin
            gap++;
            timer_tick = (gap >= 4);
            if (timer_tick) gap = 0;
            @(posedge clock); #1;
            c++;
         end
      end
      timer_tick = 1'b0;
      check("rst_reach_pulse", seen_e, 1);
      #3 rst = 1'b1;
      #1;
      check("rst_e", m_e, 0);
      check("rst_busy", m_busy, 0);
      check("rst_te", m_te, 0);
      check("rst_db", m_db, 0);
      repeat (3) begin
         @(posedge clock); #1;
         if (m_done !== 1'b0) no_done = 0;
      end
      rst = 1'b0;
      check("rst_no_done", no_done, 1);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 8'h41, 10, 10, 10, 1, 2, 4};
      vecs[1] = '{1'b0, 1'b0, 8'h01, 10, 10, 10, 1, 2, 19};
      vecs[2] = '{1'b0, 1'b0, 8'h38, 10, 10, 10, 1, 2, 4};
      vecs[3] = '{1'b0, 1'b0, 8'h02, 1, 1, 1, 1, 2, 19};
      vecs[4] = '{1'b0, 1'b0, 8'h03, 2, 2, 2, 1, 2, 19};
      vecs[5] = '{1'b0, 1'b1, 8'h01, 3, 3, 3, 1, 2, 4};
      vecs[6] = '{1'b0, 1'b0, 8'h04, 1, 1, 1, 1, 2, 4};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 4, 4, 4, 1, 2, 4};
      vecs[8] = '{1'b1, 1'b1, 8'hA5, 3, 17, 5, 2, 5, 7};
      vecs[9] = '{1'b1, 1'b0, 8'h01, 1, 1, 1, 2, 5, 22};

      #1 rst = 1'b1;
      #10;
      cur_vec = 0;
      check("reset_busy1", busy1, 0);
      check("reset_e1", e1, 0);
      check("reset_te1", te1, 0);
      check("reset_done1", done1, 0);
      check("reset_db1", db1, 0);
      check("reset_rs1", rs1, 0);
      check("reset_rw1", rw1, 0);
      check("reset_busy2", busy2, 0);
      check("reset_db2", db2, 0);
      @(posedge clock); #1;
      rst = 1'b0;

      // ticks while idle change nothing
      timer_tick = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      timer_tick = 1'b0;
      check("idle_tick_busy", busy1, 0);
      check("idle_tick_te", te1, 0);

      for (int i = 0; i < 10; i++) begin
         cur_vec = i;
         run_one(vecs[i]);
         @(posedge clock); #1;
      end

      run_held();
      run_reset();
      cur_vec = 61;
      run_one(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
